// File: rtl/mac_pe_pipe.sv
// Pipelined signed MAC processing element for the convolution systolic array.
// Forwards x downstream with latency 1 and produces saturated y with latency 2.
module mac_pe_pipe #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       mode,
  input  logic                       w_load,
  input  logic signed [WEIGHT_W-1:0] w_in,
  input  logic signed [DATA_W-1:0]   x_in,
  input  logic                       x_valid_in,
  input  logic                       x_last_in,
  input  logic signed [ACC_W-1:0]    y_in,
  input  logic                       acc_clr,
  output logic signed [DATA_W-1:0]   x_out,
  output logic                       x_valid_out,
  output logic                       x_last_out,
  output logic signed [ACC_W-1:0]    y_out,
  output logic                       y_valid_out,
  output logic                       sat_flag
);

  localparam int PW = DATA_W + WEIGHT_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // stage-1 tags travel with the product so mode can change every cycle
  typedef struct packed {
    logic v;
    logic last;
    logic mode;
  } s1_tag_t;

  logic signed [WEIGHT_W-1:0] r_weight;
  logic signed [DATA_W-1:0]   r_x_out;
  logic                       r_x_valid;
  logic                       r_x_last;
  logic signed [ACC_W-1:0]    r_prod;
  logic signed [ACC_W-1:0]    r_yin;
  s1_tag_t                    r_tag1;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ACC_W-1:0]    r_y_out;
  logic                       r_y_valid;
  logic                       r_sat;

  logic signed [PW-1:0]       w_x_ext;
  logic signed [PW-1:0]       w_w_ext;
  logic signed [PW-1:0]       w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_base;
  logic signed [ACC_W:0]      w_sum;
  logic                       w_ovf;
  logic signed [ACC_W-1:0]    w_sat;
  logic                       w_clamp;
  logic                       w_emit;

  // full-precision product; PW bits always hold it exactly
  assign w_x_ext    = PW'(x_in);
  assign w_w_ext    = PW'(r_weight);
  assign w_prod     = w_x_ext * w_w_ext;
  assign w_prod_ext = ACC_W'(w_prod);

  // acc_clr zeroes the base so a coincident ACCUM term starts the new sum
  always_comb begin
    w_base = r_yin;
    if (r_tag1.mode) w_base = acc_clr ? '0 : r_acc;
  end

  assign w_sum   = (ACC_W+1)'(w_base) + (ACC_W+1)'(r_prod);
  assign w_ovf   = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_sat   = !w_ovf ? w_sum[ACC_W-1:0] : (w_sum[ACC_W] ? SAT_MIN : SAT_MAX);
  assign w_clamp = r_tag1.v & w_ovf;
  assign w_emit  = r_tag1.v & (~r_tag1.mode | r_tag1.last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weight  <= '0;
      r_x_out   <= '0;
      r_x_valid <= 1'b0;
      r_x_last  <= 1'b0;
      r_prod    <= '0;
      r_yin     <= '0;
      r_tag1    <= '0;
      r_acc     <= '0;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
      r_sat     <= 1'b0;
    end else if (en) begin
      if (w_load) r_weight <= w_in;
      r_x_out   <= x_in;
      r_x_valid <= x_valid_in;
      r_x_last  <= x_last_in;
      r_prod    <= w_prod_ext;
      r_yin     <= y_in;
      r_tag1    <= '{v: x_valid_in, last: x_last_in, mode: mode};
      r_y_valid <= w_emit;
      if (w_emit) r_y_out <= w_sat;
      if (r_tag1.v && r_tag1.mode) r_acc <= r_tag1.last ? '0 : w_sat;
      else if (acc_clr)            r_acc <= '0;
      if (w_clamp)      r_sat <= 1'b1;
      else if (acc_clr) r_sat <= 1'b0;
    end
  end

  assign x_out       = r_x_out;
  assign x_valid_out = r_x_valid;
  assign x_last_out  = r_x_last;
  assign y_out       = r_y_out;
  assign y_valid_out = r_y_valid;
  assign sat_flag    = r_sat;

endmodule
